// File: rtl/mode_seq_pkg.sv
// Shared types and helpers for the audio mode sequencer.
// Holds the FSM/mode encodings, the start/stop bit positions and the selection-mask helpers.
package mode_seq_pkg;

  typedef enum logic [2:0] {BOOT, IDLE, ARM, RUN, STOPPING} state_t;
  typedef enum logic [1:0] {M_IDLE = 2'd0, M_REC = 2'd1, M_PLAY = 2'd2, M_MIX = 2'd3} mode_t;

  localparam int unsigned BIT_REC  = 0;
  localparam int unsigned BIT_PLAY = 1;
  localparam int unsigned BIT_MIX  = 2;

  // Index of the highest set bit; callers only trust it once the mask is known to be one-hot.
  function automatic logic [3:0] onehot_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [2:0] mode_onehot(input mode_t m);
    logic [2:0] oh;
    oh = '0;
    case (m)
      M_REC:   oh[BIT_REC]  = 1'b1;
      M_PLAY:  oh[BIT_PLAY] = 1'b1;
      M_MIX:   oh[BIT_MIX]  = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, one-cycle pulse on accepted rise.
// The counter restarts whenever the synchronised level returns to the accepted level.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1, sync2, stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
      o_press <= 1'b0;
    end else begin
      sync1   <= i_btn;
      sync2   <= sync1;
      o_press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        stable  <= sync2;
        cnt     <= '0;
        o_press <= sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Top-level REC/PLAY/MIX session arbiter: debounced buttons in, engine start/stop handshake out.
// state    | meaning
// BOOT     | waiting for SRAM preload, presses ignored
// IDLE     | no session, accepting REC/PLAY/MIX
// ARM      | one cycle: validate and latch selection
// RUN      | engine active, waiting for done or STOP
// STOPPING | stop issued, waiting for done or timeout
module mode_sequencer
  import mode_seq_pkg::*;
#(
  parameter int unsigned NUM_CHUNKS   = 5,
  parameter int unsigned ADDR_W       = 23,
  parameter int unsigned CHUNK_SIZE   = 1048576,
  parameter int unsigned MAX_MIX      = 4,
  parameter int unsigned DEB_CYCLES   = 50000,
  parameter int unsigned STOP_TIMEOUT = 1000000
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_btn_rec,
  input  logic                              i_btn_play,
  input  logic                              i_btn_mix,
  input  logic                              i_btn_stop,
  input  logic                              i_loaddata_done,
  input  logic [NUM_CHUNKS-1:0]             i_sel,
  input  logic [NUM_CHUNKS-1:0]             i_mix_mask,
  input  logic [2:0]                        i_speed,
  input  logic [2:0]                        i_done,
  output logic [1:0]                        o_mode,
  output logic [2:0]                        o_start,
  output logic [2:0]                        o_stop,
  output logic                              o_busy,
  output logic [ADDR_W-1:0]                 o_target_addr,
  output logic [NUM_CHUNKS-1:0]             o_src_mask,
  output logic [$clog2(NUM_CHUNKS+1)-1:0]   o_src_cnt,
  output logic [2:0]                        o_speed,
  output logic                              o_err
);
  localparam int unsigned CNT_W = $clog2(NUM_CHUNKS + 1);
  localparam int unsigned TMR_W = $clog2(STOP_TIMEOUT + 1);

  logic p_rec, p_play, p_mix, p_stop;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rec  (.i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_rec),  .o_press(p_rec));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_play (.i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_play), .o_press(p_play));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mix  (.i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_mix),  .o_press(p_mix));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_stop (.i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_stop), .o_press(p_stop));

  // STOP wins outright, so a STOP coinciding with a mode press in IDLE drops both.
  logic  cmd_stop;
  mode_t cmd_mode;
  assign cmd_stop = p_stop;
  assign cmd_mode = p_stop ? M_IDLE :
                    p_rec  ? M_REC  :
                    p_play ? M_PLAY :
                    p_mix  ? M_MIX  : M_IDLE;

  state_t              state_q, state_d;
  mode_t               req_q, req_d, mode_q, mode_d;
  logic [2:0]          start_q, start_d, stop_q, stop_d, speed_q, speed_d;
  logic                busy_q, busy_d, err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_CHUNKS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;

  logic [3:0] sel_idx;
  logic [4:0] sel_n, mix_n;
  logic       sel_ok, mix_ok, arm_ok, done_hit;

  assign sel_idx  = onehot_idx(16'(i_sel));
  assign sel_n    = popcount(16'(i_sel));
  assign mix_n    = popcount(16'(i_mix_mask));
  assign sel_ok   = (sel_n == 5'd1);
  assign mix_ok   = sel_ok && (mix_n >= 5'd1) && (32'(mix_n) <= MAX_MIX) && ((i_sel & i_mix_mask) == '0);
  assign arm_ok   = (req_q == M_MIX) ? mix_ok : sel_ok;
  assign done_hit = |(i_done & mode_onehot(mode_q));

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    speed_d = speed_q;
    tmr_d   = tmr_q;
    start_d = '0;
    stop_d  = '0;
    err_d   = 1'b0;
    case (state_q)
      BOOT: if (i_loaddata_done) state_d = IDLE;
      IDLE: begin
        if (cmd_mode != M_IDLE) begin
          req_d   = cmd_mode;
          state_d = ARM;
        end
      end
      ARM: begin
        if (arm_ok) begin
          addr_d  = ADDR_W'(64'(CHUNK_SIZE) * 64'(sel_idx));
          mask_d  = (req_q == M_MIX)  ? i_mix_mask : '0;
          cnt_d   = (req_q == M_MIX)  ? CNT_W'(mix_n) : '0;
          speed_d = (req_q == M_PLAY) ? i_speed : '0;
          mode_d  = req_q;
          start_d = mode_onehot(req_q);
          state_d = RUN;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RUN: begin
        if (done_hit) begin
          mode_d  = M_IDLE;
          state_d = IDLE;
        end else if (cmd_stop) begin
          stop_d  = mode_onehot(mode_q);
          tmr_d   = TMR_W'(STOP_TIMEOUT - 1);
          state_d = STOPPING;
        end
      end
      STOPPING: begin
        if (done_hit) begin
          mode_d  = M_IDLE;
          state_d = IDLE;
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          mode_d  = M_IDLE;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = BOOT;
    endcase
    busy_d = (state_d == ARM) || (state_d == RUN) || (state_d == STOPPING);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= BOOT;
      req_q   <= M_IDLE;
      mode_q  <= M_IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      speed_q <= '0;
      tmr_q   <= '0;
      start_q <= '0;
      stop_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      speed_q <= speed_d;
      tmr_q   <= tmr_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign o_mode        = mode_q;
  assign o_start       = start_q;
  assign o_stop        = stop_q;
  assign o_busy        = busy_q;
  assign o_target_addr = addr_q;
  assign o_src_mask    = mask_q;
  assign o_src_cnt     = cnt_q;
  assign o_speed       = (mode_q == M_PLAY) ? speed_q : '0;
  assign o_err         = err_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer with short debounce and stop-timeout windows.
module tb_mode_sequencer;
  localparam int unsigned NC = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    btn = 4'b0;  // {stop, mix, play, rec}
  logic          ld = 1'b0;
  logic [NC-1:0] sel = '0, mask = '0;
  logic [2:0]    speed = '0, done = '0;
  logic [1:0]    mode;
  logic [2:0]    start, stop, spd_o;
  logic          busy, err;
  logic [22:0]   addr;
  logic [NC-1:0] src_mask;
  logic [2:0]    src_cnt;

  int errors = 0;
  int checks = 0;

  mode_sequencer #(.NUM_CHUNKS(NC), .ADDR_W(23), .CHUNK_SIZE(1048576), .MAX_MIX(4),
                   .DEB_CYCLES(4), .STOP_TIMEOUT(20)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_btn_rec(btn[0]), .i_btn_play(btn[1]), .i_btn_mix(btn[2]), .i_btn_stop(btn[3]),
    .i_loaddata_done(ld), .i_sel(sel), .i_mix_mask(mask), .i_speed(speed), .i_done(done),
    .o_mode(mode), .o_start(start), .o_stop(stop), .o_busy(busy),
    .o_target_addr(addr), .o_src_mask(src_mask), .o_src_cnt(src_cnt),
    .o_speed(spd_o), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold buttons for the sync + debounce window; returns with the press pulse just registered.
  task automatic press(input logic [3:0] b);
    btn = b;
    step(6);
    btn = 4'b0;
  endtask

  initial begin
    step(2);
    chk("rst_mode", 32'(mode), 0);     chk("rst_start", 32'(start), 0);
    chk("rst_stop", 32'(stop), 0);     chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(addr), 0);     chk("rst_cnt", 32'(src_cnt), 0);
    chk("rst_err", 32'(err), 0);
    rst = 1'b0;

    // BOOT ignores presses
    press(4'b0001);
    step(2);
    chk("boot_start", 32'(start), 0);  chk("boot_mode", 32'(mode), 0);
    chk("boot_busy", 32'(busy), 0);
    step(8);
    ld = 1'b1;
    step(1);

    // PLAY on chunk 2
    sel = 5'b00100; speed = 3'd3;
    press(4'b0010);
    step(1);
    chk("play_arm_busy", 32'(busy), 1); chk("play_arm_start", 32'(start), 0);
    step(1);
    chk("play_start", 32'(start), 32'b010); chk("play_mode", 32'(mode), 2);
    chk("play_addr", 32'(addr), 32'h200000); chk("play_speed", 32'(spd_o), 3);
    step(1);
    chk("play_start_once", 32'(start), 0);
    done = 3'b010; step(1); done = 3'b000;
    chk("play_done_mode", 32'(mode), 0); chk("play_done_busy", 32'(busy), 0);
    step(8);

    // valid MIX
    sel = 5'b00001; mask = 5'b00110;
    press(4'b0100);
    step(2);
    chk("mix_start", 32'(start), 32'b100); chk("mix_cnt", 32'(src_cnt), 2);
    chk("mix_mask", 32'(src_mask), 32'b00110); chk("mix_addr", 32'(addr), 0);
    chk("mix_speed", 32'(spd_o), 0); chk("mix_mode", 32'(mode), 3);
    done = 3'b100; step(1); done = 3'b000;
    chk("mix_done_mode", 32'(mode), 0);
    step(8);

    // MIX with source overlapping target
    mask = 5'b00011;
    press(4'b0100);
    step(2);
    chk("mixbad_err", 32'(err), 1); chk("mixbad_start", 32'(start), 0);
    chk("mixbad_busy", 32'(busy), 0); chk("mixbad_cnt_held", 32'(src_cnt), 2);
    step(1);
    chk("mixbad_err_pulse", 32'(err), 0);
    step(8);

    // REC: STOP and done coincide
    sel = 5'b00010;
    press(4'b0001);
    step(2);
    chk("rec_start", 32'(start), 32'b001); chk("rec_addr", 32'(addr), 32'h100000);
    press(4'b1000);
    done = 3'b001; step(1); done = 3'b000;
    chk("race_stop", 32'(stop), 0); chk("race_mode", 32'(mode), 0);
    chk("race_busy", 32'(busy), 0);
    step(1);
    chk("race_stop_late", 32'(stop), 0);
    step(8);

    // REC: STOP, then done five cycles later
    press(4'b0001);
    step(2);
    chk("rec2_start", 32'(start), 32'b001);
    press(4'b1000);
    step(1);
    chk("stop_pulse", 32'(stop), 32'b001); chk("stop_busy", 32'(busy), 1);
    step(1);
    chk("stop_once", 32'(stop), 0);
    step(3);
    done = 3'b001; step(1); done = 3'b000;
    chk("stop_done_mode", 32'(mode), 0); chk("stop_done_busy", 32'(busy), 0);
    chk("stop_done_err", 32'(err), 0);
    step(8);

    // STOP with no done: timeout
    press(4'b0001);
    step(2);
    press(4'b1000);
    step(1);
    chk("to_stop", 32'(stop), 32'b001);
    step(19);
    chk("to_err_early", 32'(err), 0); chk("to_busy_early", 32'(busy), 1);
    step(1);
    chk("to_err", 32'(err), 1); chk("to_busy", 32'(busy), 0); chk("to_mode", 32'(mode), 0);
    step(1);
    chk("to_err_pulse", 32'(err), 0);
    step(8);

    // bouncing REC never accepted
    for (int i = 0; i < 8; i++) begin
      btn = 4'b0001; step(2);
      btn = 4'b0000; step(1);
    end
    step(6);
    chk("bounce_busy", 32'(busy), 0); chk("bounce_mode", 32'(mode), 0);

    // simultaneous REC+PLAY: REC wins
    sel = 5'b00100;
    press(4'b0011);
    step(2);
    chk("prio_start", 32'(start), 32'b001); chk("prio_mode", 32'(mode), 1);
    chk("prio_speed", 32'(spd_o), 0);

    // reset mid-RUN
    rst = 1'b1; step(1);
    chk("mid_rst_mode", 32'(mode), 0);   chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_addr", 32'(addr), 0);   chk("mid_rst_stop", 32'(stop), 0);
    chk("mid_rst_speed", 32'(spd_o), 0); chk("mid_rst_cnt", 32'(src_cnt), 0);
    chk("mid_rst_mask", 32'(src_mask), 0); chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_start", 32'(start), 0);
    ld = 1'b0; rst = 1'b0;
    press(4'b0010);
    step(2);
    chk("post_rst_boot_busy", 32'(busy), 0); chk("post_rst_boot_start", 32'(start), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mode_sequencer.md
Name: mode_sequencer

Overview:
Parametrised successor to the top-level audio control FSM. It turns four raw GPIO buttons into debounced command pulses and arbitrates REC/PLAY/MIX sessions over NUM_CHUNKS SRAM chunks. It validates and latches the chunk selections, then drives a one-hot start/stop/done handshake to the record, play and mix engines. Unlike the previous generation, it adds the following:
- debounce
- simultaneous-press priority
- selection validation with an error pulse
- a stop-acknowledge watchdog
- chunk count generalised by parameter

Parameters:
NUM_CHUNKS, 5, number of SRAM chunks (2..16)
ADDR_W, 23, SRAM word-address width
CHUNK_SIZE, 1048576, words per chunk; chunk k base = k*CHUNK_SIZE; NUM_CHUNKS*CHUNK_SIZE <= 2**ADDR_W
MAX_MIX, 4, maximum number of mix sources
DEB_CYCLES, 50000, cycles a synchronised button must be stable before it is accepted
STOP_TIMEOUT, 1000000, cycles allowed between o_stop and the engine's done

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous, active-high reset
i_btn_rec / i_btn_play / i_btn_mix / i_btn_stop  in  1 each  raw asynchronous button levels, active-high
i_loaddata_done  in  1  level: SRAM preload finished
i_sel  in  NUM_CHUNKS  one-hot target chunk
i_mix_mask  in  NUM_CHUNKS  mix source chunks
i_speed  in  3  play speed code
i_done  in  3  engine done pulses, one-hot {mix,play,rec}
o_mode  out  2  0 idle, 1 rec, 2 play, 3 mix
o_start  out  3  one-cycle start pulse {mix,play,rec}
o_stop  out  3  one-cycle stop pulse {mix,play,rec}
o_busy  out  1  high in ARM/RUN/STOPPING
o_target_addr  out  ADDR_W  base address of the latched target chunk
o_src_mask  out  NUM_CHUNKS  latched mix sources
o_src_cnt  out  clog2(NUM_CHUNKS+1)  popcount of o_src_mask
o_speed  out  3  latched speed; 0 unless mode is PLAY
o_err  out  1  one-cycle error pulse

Behaviour:
- Reset (i_rst high at a clock edge):
  - state goes to BOOT.
  - All outputs go to 0 (o_mode=0, o_start=0, o_stop=0, o_busy=0, o_target_addr=0, o_src_mask=0, o_src_cnt=0, o_speed=0, o_err=0).
  - Debounce counters and synchronisers are cleared.
  - Reset mid-session aborts the session with no stop pulse.
- Buttons:
  - Each button passes through a 2-FF synchroniser, then a counter that accepts a new level only after DEB_CYCLES consecutive equal samples.
  - The accepted rising edge produces a one-cycle press pulse.
  - Press pulse latency is 2 + DEB_CYCLES cycles after a stable input.
  - Release edges produce nothing.
- Press priority when pulses coincide: STOP > REC > PLAY > MIX. Only the winner is acted on; the rest are dropped.
- BOOT: move to IDLE on the cycle after i_loaddata_done is sampled high. All presses are ignored in BOOT.
- IDLE:
  - A REC, PLAY or MIX press moves to ARM and records the requested mode.
  - A STOP press is ignored.
- ARM (exactly one cycle): validate and latch the inputs.
  - REC/PLAY are valid iff i_sel is exactly one-hot.
  - MIX is valid iff i_sel is one-hot, 1 <= popcount(i_mix_mask) <= MAX_MIX, and i_sel & i_mix_mask == 0.
  - Invalid: o_err=1 for one cycle, return to IDLE, latched outputs unchanged.
  - Valid:
    - o_target_addr = idx(i_sel)*CHUNK_SIZE.
    - o_src_mask and o_src_cnt are latched for MIX only, else 0.
    - o_speed = i_speed for PLAY only, else 0.
    - o_mode is set.
    - Go to RUN.
- RUN:
  - o_start[mode] is high only on the first RUN cycle.
  - A press pulse in IDLE at cycle n gives ARM at n+1 and o_start at n+2.
  - i_done[mode] returns to IDLE at the next edge; o_mode becomes 0 and the latched fields hold their values.
  - A STOP press gives o_stop[mode] next cycle and moves to STOPPING.
  - If done and STOP arrive in the same cycle, done wins and no o_stop is issued.
  - Other presses, and i_done bits for other modes, are ignored.
  - Selection inputs are not re-sampled during RUN.
- STOPPING:
  - Wait for i_done[mode], then go to IDLE.
  - A cycle counter starts at o_stop. If it reaches STOP_TIMEOUT without done: o_err pulse and forced return to IDLE.
  - Further STOP presses are ignored.
- o_busy = (state is ARM, RUN or STOPPING), registered with the state.

Decomposition:
- Package mode_seq_pkg holds:
  - the state enum {BOOT, IDLE, ARM, RUN, STOPPING}
  - the mode enum {M_IDLE=0, M_REC=1, M_PLAY=2, M_MIX=3}
  - the start/stop bit indices
  - functions onehot_idx and popcount
- Sub-module btn_debounce (synchroniser + counter + rise-pulse), parametrised by DEB_CYCLES, instantiated four times.

Test Plan:
- Bench uses DEB_CYCLES=4, STOP_TIMEOUT=20.
- Hold i_loaddata_done=0, press REC -> no o_start and o_mode=0. Raise i_loaddata_done -> IDLE next cycle.
- i_sel=5'b00100, press PLAY with i_speed=3 -> o_start=3'b010 exactly once, 2 cycles after the press pulse; o_target_addr=2*CHUNK_SIZE=0x200000, o_speed=3. Pulse i_done[1] -> o_mode=0 next cycle.
- MIX with i_sel=5'b00001 and i_mix_mask=5'b00110 -> o_src_cnt=2, o_target_addr=0. Repeat with i_mix_mask=5'b00011 (overlaps target) -> o_err pulse, no o_start.
- In REC RUN, STOP and i_done[0] in the same cycle -> no o_stop, back to IDLE. Next session: STOP alone -> o_stop=3'b001 one cycle, done 5 cycles later -> IDLE.
- STOP with no done -> o_err exactly 20 cycles after o_stop, forced to IDLE. Separately, a button bouncing with period < 4 cycles -> no press pulse.
- REC and PLAY accepted in the same cycle -> REC session starts. Assert i_rst mid-RUN -> all outputs 0 next cycle, state BOOT.
